id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 16-bit, 16-register pipeline. Registers decoded operands and control from ID, and drives the EX-side register numbers (`ex_rs`, `ex_rt`), `ex_opcode` and write controls consumed by the forwarding unit. Also performs load-use hazard detection, bubble insertion, branch flush and whole-pipe freeze on memory stall. Keeps a saturating count of inserted bubbles.

---
 rtl/id_ex_stage.sv | 103 ++++++++++
 tb/tb_id_ex_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, memory-stall freeze and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_rs,
    input  logic [3:0]        id_rt,
    input  logic [3:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [3:0]        id_opcode,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              mem_stall,
    input  logic              branch_flush,
    output logic              ex_valid,
    output logic [3:0]        ex_rs,
    output logic [3:0]        ex_rt,
    output logic [3:0]        ex_rd,
    output logic [3:0]        ex_opcode,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic rs_hit;
    logic rt_hit;
    logic insert_bubble;
    logic front_write;

    // A load into r0 never creates a hazard.
    assign rs_hit = (ex_rd == id_rs);
    assign rt_hit = id_uses_rt & (ex_rd == id_rt);
    assign load_use_stall = id_valid & ex_valid & ex_memread & (ex_rd != 4'd0) & (rs_hit | rt_hit);

    // A flushed ID instruction is being killed, so holding the front end would be pointless.
    assign front_write    = ~mem_stall & ~(load_use_stall & ~branch_flush);
    assign pc_write_en    = front_write;
    assign if_id_write_en = front_write;

    assign insert_bubble = branch_flush | load_use_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            bubble_cnt  <= '0;
        end else if (mem_stall) begin
            // Freeze: every EX register and the counter keep their values.
        end else if (insert_bubble) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            if (bubble_cnt != {CNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end else begin
            ex_valid    <= id_valid;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_opcode   <= id_opcode;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm      <= id_imm;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table plus hand-written
// freeze, reset and counter-saturation sequences.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic        id_valid;
    logic [3:0]  id_rs, id_rt, id_rd, id_opcode;
    logic        id_uses_rt;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_regwrite, id_memread, id_memwrite;
    logic        mem_stall, branch_flush, branch_flush2;

    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [3:0]  ex_rs, ex_rt, ex_rd, ex_opcode;
    logic [15:0] ex_rs_data, ex_rt_data, ex_imm;
    logic        pc_write_en, if_id_write_en, load_use_stall;
    logic [15:0] bubble_cnt;

    logic        s_valid, s_regwrite, s_memread, s_memwrite;
    logic [3:0]  s_rs, s_rt, s_rd, s_opcode;
    logic [15:0] s_rs_data, s_rt_data, s_imm;
    logic        s_pc_we, s_ifid_we, s_stall;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_opcode(id_opcode),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .mem_stall(mem_stall), .branch_flush(branch_flush),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_opcode(ex_opcode), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .pc_write_en(pc_write_en),
        .if_id_write_en(if_id_write_en), .load_use_stall(load_use_stall),
        .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a few edges.
    id_ex_stage #(.DATA_W(16), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_opcode(id_opcode),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .mem_stall(mem_stall), .branch_flush(branch_flush2),
        .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .ex_opcode(s_opcode), .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data),
        .ex_imm(s_imm), .ex_regwrite(s_regwrite), .ex_memread(s_memread),
        .ex_memwrite(s_memwrite), .pc_write_en(s_pc_we),
        .if_id_write_en(s_ifid_we), .load_use_stall(s_stall),
        .bubble_cnt(s_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  rs, rt, rd;
        logic        ut;
        logic [3:0]  op;
        logic [15:0] rsd;
        logic        rw, mr, fl;
        logic        e_stall, e_pcwe, e_v;
        logic [3:0]  e_rs, e_rt, e_rd;
        logic        e_mr;
        logic [3:0]  e_op;
        logic [15:0] e_cnt, e_rsd;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                                input logic [3:0] rd, input logic ut, input logic [3:0] op,
                                input logic [15:0] rsd, input logic rw, input logic mr,
                                input logic fl, input logic e_stall, input logic e_pcwe,
                                input logic e_v, input logic [3:0] e_rs, input logic [3:0] e_rt,
                                input logic [3:0] e_rd, input logic e_mr, input logic [3:0] e_op,
                                input logic [15:0] e_cnt, input logic [15:0] e_rsd);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.rd = rd; t.ut = ut; t.op = op; t.rsd = rsd;
        t.rw = rw; t.mr = mr; t.fl = fl;
        t.e_stall = e_stall; t.e_pcwe = e_pcwe; t.e_v = e_v; t.e_rs = e_rs; t.e_rt = e_rt;
        t.e_rd = e_rd; t.e_mr = e_mr; t.e_op = e_op; t.e_cnt = e_cnt; t.e_rsd = e_rsd;
        return t;
    endfunction

    // Scoreboard check
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [3:0] rd, input logic ut, input logic [3:0] op,
                            input logic [15:0] rsd, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ut; id_opcode = op;
        id_rs_data = rsd; id_rt_data = ~rsd; id_imm = rsd + 16'd1;
        id_regwrite = rw; id_memread = mr; id_memwrite = 1'b0;
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        drive_id(t.v, t.rs, t.rt, t.rd, t.ut, t.op, t.rsd, t.rw, t.mr);
        branch_flush = t.fl;
        #1;
        chk($sformatf("v%0d_stall", idx), {31'd0, load_use_stall}, {31'd0, t.e_stall});
        chk($sformatf("v%0d_pcwe", idx), {31'd0, pc_write_en}, {31'd0, t.e_pcwe});
        chk($sformatf("v%0d_ifidwe", idx), {31'd0, if_id_write_en}, {31'd0, t.e_pcwe});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_valid", idx), {31'd0, ex_valid}, {31'd0, t.e_v});
        chk($sformatf("v%0d_rs", idx), {28'd0, ex_rs}, {28'd0, t.e_rs});
        chk($sformatf("v%0d_rt", idx), {28'd0, ex_rt}, {28'd0, t.e_rt});
        chk($sformatf("v%0d_rd", idx), {28'd0, ex_rd}, {28'd0, t.e_rd});
        chk($sformatf("v%0d_memread", idx), {31'd0, ex_memread}, {31'd0, t.e_mr});
        chk($sformatf("v%0d_opcode", idx), {28'd0, ex_opcode}, {28'd0, t.e_op});
        chk($sformatf("v%0d_cnt", idx), {16'd0, bubble_cnt}, {16'd0, t.e_cnt});
        chk($sformatf("v%0d_rsdata", idx), {16'd0, ex_rs_data}, {16'd0, t.e_rsd});
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        mem_stall = 1'b0; branch_flush = 1'b0; branch_flush2 = 1'b0;
        drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

        //         v  rs    rt    rd     ut  op    rsd       rw mr fl | st pc ev rs   rt   rd    mr  op    cnt    rsd
        vecs[0]  = mk(1, 4'd2, 4'd3, 4'd4,  0, 4'd1, 16'h1234, 1, 0, 0,  0, 1, 1, 4'd2, 4'd3, 4'd4,  0, 4'd1, 16'd0, 16'h1234);
        vecs[1]  = mk(1, 4'd1, 4'd0, 4'd5,  0, 4'd2, 16'h0010, 1, 1, 0,  0, 1, 1, 4'd1, 4'd0, 4'd5,  1, 4'd2, 16'd0, 16'h0010);
        vecs[2]  = mk(1, 4'd5, 4'd7, 4'd8,  1, 4'd3, 16'hAAAA, 1, 0, 0,  1, 0, 0, 4'd0, 4'd0, 4'd0,  0, 4'd0, 16'd1, 16'h0000);
        vecs[3]  = mk(1, 4'd5, 4'd7, 4'd8,  1, 4'd3, 16'hAAAA, 1, 0, 0,  0, 1, 1, 4'd5, 4'd7, 4'd8,  0, 4'd3, 16'd1, 16'hAAAA);
        vecs[4]  = mk(1, 4'd1, 4'd2, 4'd6,  0, 4'd2, 16'h0020, 1, 1, 0,  0, 1, 1, 4'd1, 4'd2, 4'd6,  1, 4'd2, 16'd1, 16'h0020);
        vecs[5]  = mk(1, 4'd3, 4'd6, 4'd9,  0, 4'd4, 16'h0300, 1, 0, 0,  0, 1, 1, 4'd3, 4'd6, 4'd9,  0, 4'd4, 16'd1, 16'h0300);
        vecs[6]  = mk(1, 4'd1, 4'd2, 4'd0,  0, 4'd2, 16'h0040, 1, 1, 0,  0, 1, 1, 4'd1, 4'd2, 4'd0,  1, 4'd2, 16'd1, 16'h0040);
        vecs[7]  = mk(1, 4'd0, 4'd0, 4'd10, 1, 4'd5, 16'h0050, 1, 0, 0,  0, 1, 1, 4'd0, 4'd0, 4'd10, 0, 4'd5, 16'd1, 16'h0050);
        vecs[8]  = mk(1, 4'd1, 4'd2, 4'd6,  0, 4'd2, 16'h0060, 1, 1, 0,  0, 1, 1, 4'd1, 4'd2, 4'd6,  1, 4'd2, 16'd1, 16'h0060);
        vecs[9]  = mk(1, 4'd4, 4'd6, 4'd11, 1, 4'd6, 16'h0700, 1, 0, 0,  1, 0, 0, 4'd0, 4'd0, 4'd0,  0, 4'd0, 16'd2, 16'h0000);
        vecs[10] = mk(1, 4'd4, 4'd6, 4'd11, 1, 4'd6, 16'h0700, 1, 0, 0,  0, 1, 1, 4'd4, 4'd6, 4'd11, 0, 4'd6, 16'd2, 16'h0700);
        vecs[11] = mk(1, 4'd1, 4'd2, 4'd7,  0, 4'd2, 16'h0080, 1, 1, 0,  0, 1, 1, 4'd1, 4'd2, 4'd7,  1, 4'd2, 16'd2, 16'h0080);
        vecs[12] = mk(1, 4'd7, 4'd0, 4'd12, 0, 4'd7, 16'h0900, 1, 0, 1,  1, 1, 0, 4'd0, 4'd0, 4'd0,  0, 4'd0, 16'd3, 16'h0000);
        vecs[13] = mk(0, 4'd3, 4'd3, 4'd3,  0, 4'd8, 16'h0A00, 0, 0, 0,  0, 1, 0, 4'd3, 4'd3, 4'd3,  0, 4'd8, 16'd3, 16'h0A00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_rd", {28'd0, ex_rd}, 32'd0);
        chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("rst_pcwe", {31'd0, pc_write_en}, 32'd1);
        chk("rst_stall", {31'd0, load_use_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table; vector 0 also gets its remaining fields checked by hand
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i], i);
            if (i == 0) begin
                chk("v0_rtdata", {16'd0, ex_rt_data}, 32'h0000EDCB);
                chk("v0_imm", {16'd0, ex_imm}, 32'h00001235);
                chk("v0_regwrite", {31'd0, ex_regwrite}, 32'd1);
                chk("v0_memwrite", {31'd0, ex_memwrite}, 32'd0);
            end
        end

        // Memory freeze over a pending load-use hazard
        @(negedge clk);
        drive_id(1'b1, 4'd1, 4'd2, 4'd5, 1'b0, 4'd2, 16'h0B00, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("frz_load_rd", {28'd0, ex_rd}, 32'd5);
        @(negedge clk);
        drive_id(1'b1, 4'd5, 4'd0, 4'd13, 1'b0, 4'd9, 16'h0C00, 1'b1, 1'b0);
        mem_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) branch_flush = 1'b1;
            #1;
            chk($sformatf("frz%0d_stall", k), {31'd0, load_use_stall}, 32'd1);
            chk($sformatf("frz%0d_pcwe", k), {31'd0, pc_write_en}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("frz%0d_rd", k), {28'd0, ex_rd}, 32'd5);
            chk($sformatf("frz%0d_valid", k), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("frz%0d_memread", k), {31'd0, ex_memread}, 32'd1);
            chk($sformatf("frz%0d_rsdata", k), {16'd0, ex_rs_data}, 32'h00000B00);
            chk($sformatf("frz%0d_cnt", k), {16'd0, bubble_cnt}, 32'd3);
            @(negedge clk);
        end
        mem_stall = 1'b0;
        branch_flush = 1'b0;
        #1;
        chk("rel_pcwe", {31'd0, pc_write_en}, 32'd0);
        @(posedge clk); #1;
        chk("rel_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("rel_bubble_rd", {28'd0, ex_rd}, 32'd0);
        chk("rel_cnt", {16'd0, bubble_cnt}, 32'd4);
        @(posedge clk); #1;
        chk("rel_capture_rs", {28'd0, ex_rs}, 32'd5);
        chk("rel_capture_rd", {28'd0, ex_rd}, 32'd13);
        chk("rel_capture_cnt", {16'd0, bubble_cnt}, 32'd4);

        // Asynchronous reset mid-stall, between clock edges
        @(negedge clk);
        drive_id(1'b1, 4'd1, 4'd2, 4'd5, 1'b0, 4'd2, 16'h0D00, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_id(1'b1, 4'd5, 4'd0, 4'd14, 1'b0, 4'd9, 16'h0E00, 1'b1, 1'b0);
        mem_stall = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_rd", {28'd0, ex_rd}, 32'd0);
        chk("arst_memread", {31'd0, ex_memread}, 32'd0);
        chk("arst_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("arst_stall", {31'd0, load_use_stall}, 32'd0);
        @(negedge clk);
        mem_stall = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_rd", {28'd0, ex_rd}, 32'd14);
        chk("post_rst_rsdata", {16'd0, ex_rs_data}, 32'h00000E00);

        // Saturation on the 4-bit counter: 14 bubbles reach 0xE, then 3 more stick at 0xF
        @(negedge clk);
        drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
        rst2_n = 1'b1;
        branch_flush2 = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("sat_preload", {28'd0, s_cnt}, 32'hE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat%0d_cnt", k), {28'd0, s_cnt}, 32'hF);
        end
        branch_flush2 = 1'b0;

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
